// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Optional fetch anti-starvation is enabled with `define MEM_ARB_FAIR_EN.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  input  logic          IFlush,
  output logic [DW-1:0] IRdata,
  output logic          IValid,
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWdata,
  output logic [DW-1:0] DRdata,
  output logic          DValid,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWdata,
  input  logic [DW-1:0] MemRdata,
  input  logic          MemReady,
  output logic          StallF,
  output logic          StallM,
  output logic          Busy
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t state, stateNxt;
  logic   cancel;
  logic   fetchWant, fetchFirst, grantD, grantI, done;

  assign fetchWant = IReq & ~IFlush;

`ifdef MEM_ARB_FAIR_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starveCnt;

  assign fetchFirst = fetchWant && (starveCnt == CW'(STARVE_MAX));

  // Counts data grants that left a live fetch waiting; a fetch grant resets it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                starveCnt <= '0;
    else if (grantI)           starveCnt <= '0;
    else if (grantD && fetchWant) starveCnt <= starveCnt + 1'b1;
  end
`else
  // Data always wins; the comparison is constant false.
  assign fetchFirst = (STARVE_MAX < 0);
`endif

  assign grantD = (state == IDLE) && DReq && !fetchFirst;
  assign grantI = (state == IDLE) && fetchWant && !grantD;
  assign done   = (state != IDLE) && MemReady;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (grantD)      stateNxt = BUSY_D;
        else if (grantI) stateNxt = BUSY_I;
      end
      BUSY_I, BUSY_D: if (MemReady) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWdata <= '0;
      IRdata   <= '0;
      DRdata   <= '0;
      IValid   <= 1'b0;
      DValid   <= 1'b0;
      cancel   <= 1'b0;
    end else begin
      IValid <= 1'b0;
      DValid <= 1'b0;
      if (grantD) begin
        MemReq   <= 1'b1;
        MemWe    <= DWe;
        MemAddr  <= DAddr;
        MemWdata <= DWdata;
      end else if (grantI) begin
        MemReq  <= 1'b1;
        MemWe   <= 1'b0;
        MemAddr <= IAddr;
      end
      if (state == BUSY_I && IFlush) cancel <= 1'b1;
      if (done) begin
        MemReq <= 1'b0;
        cancel <= 1'b0;
        if (state == BUSY_D) begin
          DValid <= 1'b1;
          if (!MemWe) DRdata <= MemRdata;
        // A flush on the completion cycle itself also suppresses the fetch.
        end else if (!(cancel || IFlush)) begin
          IValid <= 1'b1;
          IRdata <= MemRdata;
        end
      end
    end
  end

  assign StallF = IReq & ~IValid;
  assign StallM = DReq & ~DValid;
  assign Busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          IReq = 1'b0, IFlush = 1'b0, DReq = 1'b0, DWe = 1'b0, MemReady = 1'b0;
  logic [AW-1:0] IAddr = '0, DAddr = '0;
  logic [DW-1:0] DWdata = '0, MemRdata = '0;
  logic [DW-1:0] IRdata, DRdata, MemWdata;
  logic [AW-1:0] MemAddr;
  logic          IValid, DValid, MemReq, MemWe, StallF, StallM, Busy;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IReq(IReq), .IAddr(IAddr), .IFlush(IFlush), .IRdata(IRdata), .IValid(IValid),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata), .DRdata(DRdata), .DValid(DValid),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .MemReady(MemReady),
    .StallF(StallF), .StallM(StallM), .Busy(Busy)
  );

  int passCnt = 0;
  int totalCnt = 0;

  // Model: the transaction currently owning memory, plus what the requesters should see.
  bit          mActive, mIsD, mWe, mCancel, mIValid, mDValid;
  logic [31:0] mAddr, mWdata, mIRdata, mDRdata;
  int          mStarve;
  bit          prevMemReq;
  bit          dutGrantIsI[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    mActive = 0; mIsD = 0; mWe = 0; mCancel = 0; mIValid = 0; mDValid = 0;
    mAddr = '0; mWdata = '0; mIRdata = '0; mDRdata = '0; mStarve = 0;
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic modelStep();
    bit iWant, fetchFirst;
    iWant = IReq && !IFlush;
    fetchFirst = 0;
    mIValid = 0;
    mDValid = 0;
    if (mActive) begin
      if (!mIsD && IFlush) mCancel = 1;
      if (MemReady) begin
        mActive = 0;
        if (mIsD) begin
          mDValid = 1;
          if (!mWe) mDRdata = MemRdata;
        end else if (!mCancel) begin
          mIValid = 1;
          mIRdata = MemRdata;
        end
        mCancel = 0;
      end
    end else begin
`ifdef MEM_ARB_FAIR_EN
      fetchFirst = iWant && (mStarve == SM);
`endif
      if (DReq && !fetchFirst) begin
        mActive = 1; mIsD = 1; mWe = DWe; mAddr = DAddr; mWdata = DWdata;
        if (iWant) mStarve++;
      end else if (iWant) begin
        mActive = 1; mIsD = 0; mWe = 0; mAddr = IAddr;
        mStarve = 0;
      end
    end
  endtask

  task automatic checkOutputs();
    chk("Busy", Busy, mActive);
    chk("MemReq", MemReq, mActive);
    chk("IValid", IValid, mIValid);
    chk("DValid", DValid, mDValid);
    chk("IRdata", IRdata, mIRdata);
    chk("DRdata", DRdata, mDRdata);
    if (mActive) begin
      chk("MemAddr", MemAddr, mAddr);
      chk("MemWe", MemWe, mWe);
      if (mIsD) chk("MemWdata", MemWdata, mWdata);
    end
    if (MemReq && !prevMemReq) dutGrantIsI.push_back(MemAddr == 32'h40);
    prevMemReq = MemReq;
  endtask

  // Inputs are already driven (at a falling edge); run one clock and check.
  task automatic cycle();
    #1;
    chk("StallF", StallF, IReq && !mIValid);
    chk("StallM", StallM, DReq && !mDValid);
    modelStep();
    @(posedge CLK);
    @(negedge CLK);
    checkOutputs();
  endtask

  initial begin
    logic [9:0] grantBits, expBits;
    modelReset();
    prevMemReq = 0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutputs();
    chk("rst_MemWe", MemWe, 0);
    chk("rst_MemAddr", MemAddr, 0);
    chk("rst_MemWdata", MemWdata, 0);
    RST_N = 1'b1;

    // Single fetch, memory always ready
    IReq = 1; IAddr = 32'h40; MemReady = 1; MemRdata = 32'h8C010004;
    cycle();
    chk("fetch_MemReq", MemReq, 1);
    cycle();
    chk("fetch_IValid", IValid, 1);
    chk("fetch_IRdata", IRdata, 32'h8C010004);
    IReq = 0;
    cycle();

    // Store with two wait cycles
    DReq = 1; DWe = 1; DAddr = 32'h100; DWdata = 32'hDEADBEEF; MemReady = 0;
    cycle();
    chk("store_MemWe", MemWe, 1);
    cycle(); cycle();
    MemReady = 1;
    cycle();
    chk("store_DValid", DValid, 1);
    chk("store_DRdata", DRdata, 0);
    DReq = 0;
    cycle();

    // Load back with two wait cycles
    DReq = 1; DWe = 0; DAddr = 32'h100; MemRdata = 32'hDEADBEEF; MemReady = 0;
    cycle(); cycle(); cycle();
    MemReady = 1;
    cycle();
    chk("load_DRdata", DRdata, 32'hDEADBEEF);
    DReq = 0;
    cycle();

    // Simultaneous requests: data first, fetch on the next idle cycle
    IReq = 1; IAddr = 32'h44; DReq = 1; DWe = 0; DAddr = 32'h200;
    MemRdata = 32'h0BADF00D; MemReady = 1;
    cycle();
    chk("both_firstAddr", MemAddr, 32'h200);
    cycle();
    chk("both_DValid", DValid, 1);
    DReq = 0;
    cycle();
    chk("both_secondAddr", MemAddr, 32'h44);
    cycle();
    chk("both_IValid", IValid, 1);
    IReq = 0;
    cycle();

    // Flushed fetch completes on the bus but is never returned
    IReq = 1; IAddr = 32'h48; MemReady = 0;
    cycle();
    IFlush = 1;
    cycle();
    IFlush = 0; MemRdata = 32'h12345678; MemReady = 1;
    cycle();
    chk("flush_IValid", IValid, 0);
    chk("flush_IRdata", IRdata, 32'h0BADF00D);
    chk("flush_Busy", Busy, 0);
    IReq = 0;
    cycle();

    // Reset asserted mid data transaction
    DReq = 1; DWe = 0; DAddr = 32'h300; MemReady = 0;
    cycle(); cycle();
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_MemReq", MemReq, 0);
    chk("midrst_Busy", Busy, 0);
    modelReset();
    DReq = 0; MemReady = 1;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    checkOutputs();
    repeat (3) cycle();
    chk("midrst_noDValid", DValid, 0);

    // Both requesters held constantly: grant order of the first ten transactions
    dutGrantIsI.delete();
    IReq = 1; IAddr = 32'h40; DReq = 1; DWe = 0; DAddr = 32'h100; MemReady = 1;
    repeat (22) cycle();
    chk("held_grantCount", dutGrantIsI.size() >= 10, 1);
    grantBits = '0;
    for (int i = 0; i < 10 && i < dutGrantIsI.size(); i++) grantBits[i] = dutGrantIsI[i];
`ifdef MEM_ARB_FAIR_EN
    expBits = 10'b1000010000;
`else
    expBits = 10'b0000000000;
`endif
    chk("held_grantOrder", grantBits, expBits);
    IReq = 0; DReq = 0;
    repeat (3) cycle();

    // Randomized traffic with level-held requests
    for (int n = 0; n < 3000; n++) begin
      if (!IReq || IValid) begin
        IReq = ($urandom_range(2) == 0);
        IAddr = $urandom & 32'hFFFC;
      end
      if (!DReq || DValid) begin
        DReq = ($urandom_range(2) == 0);
        DWe = $urandom_range(1);
        DAddr = $urandom & 32'hFFFC;
        DWdata = $urandom;
      end
      IFlush = ($urandom_range(7) == 0);
      if (IFlush) IAddr = $urandom & 32'hFFFC;
      MemReady = $urandom_range(1);
      MemRdata = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port unified memory between instruction fetch (IF) and data access (MEM) in the 5-stage pipeline.
- Sequences each memory transaction through a small FSM.
- Returns read data with a one-cycle valid pulse.
- Drives the StallF/StallM requests consumed by the hazard logic while a requester waits.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win (used only with MEM_ARB_FAIR_EN).

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IReq  input  1  fetch request; level-held until IValid.
- IAddr  input  AW  fetch address.
- IFlush  input  1  cancels the in-flight or pending fetch (branch/jump redirect).
- IRdata  output  DW  fetched word.
- IValid  output  1  one-cycle pulse when fetch completes.
- DReq  input  1  data request; level-held until DValid.
- DWe  input  1  1 = store, 0 = load.
- DAddr  input  AW  data address.
- DWdata  input  DW  store data.
- DRdata  output  DW  load data.
- DValid  output  1  one-cycle pulse when data access completes (load or store).
- MemReq  output  1  memory request.
- MemWe  output  1  memory write enable.
- MemAddr  output  AW  memory address.
- MemWdata  output  DW  memory write data.
- MemRdata  input  DW  memory read data, valid when MemReady=1.
- MemReady  input  1  memory completes the current request this cycle.
- StallF  output  1  IReq & ~IValid (combinational).
- StallM  output  1  DReq & ~DValid (combinational).
- Busy  output  1  FSM not in IDLE.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Reset is asynchronous, entered on RST_N=0.
- Reset values:
  - State = IDLE.
  - MemReq, MemWe, IValid, DValid = 0.
  - MemAddr, MemWdata, IRdata, DRdata = 0.
  - Starvation counter = 0.
- Arbitration in IDLE (a grant occurs only when IDLE sees at least one request):
  - DReq=1: latch DAddr/DWdata/DWe into the Mem* registers, go to BUSY_D.
  - Else IReq=1 & ~IFlush: latch IAddr, MemWe=0, go to BUSY_I.
  - Neither: stay in IDLE.
- MemReq is registered. It rises the cycle after the grant and holds with stable Mem* outputs until the cycle where MemReady=1.
- Completion edge (MemReady=1 in BUSY_x):
  - MemReq=0, return to IDLE.
  - BUSY_D load: DRdata<=MemRdata, DValid=1 for one cycle.
  - BUSY_D store: DValid=1 for one cycle, DRdata unchanged.
  - BUSY_I: IRdata<=MemRdata, IValid=1 for one cycle unless cancelled.
- Cancelled fetch:
  - IFlush seen any cycle in BUSY_I sets a sticky cancel bit.
  - The memory transaction still completes (no abort), but IValid stays 0 and IRdata is unchanged.
  - The cancel bit clears on return to IDLE.
- IDLE lasts at least one cycle between transactions, so best-case latency from request to Valid is 3 cycles with MemReady tied high.
- MemReady while IDLE is ignored.
- Requester rules:
  - A requester deasserting Req before Valid is a protocol violation; behaviour is undefined.
  - A request still asserted in the Valid cycle is treated as a new request and may be granted at the next IDLE.
- Both requests pending in IDLE: data wins by default (see Optional Feature).
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values; the partial memory access is abandoned.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined:
  - A counter of width clog2(STARVE_MAX+1) increments on each IDLE grant to data while IReq & ~IFlush.
  - When the counter equals STARVE_MAX and both are pending, fetch wins.
  - The counter clears on any fetch grant, and holds when IReq=0.
- Undefined: no counter; data always wins.

Test Plan:
- Single fetch, MemReady tied 1, IReq=1 with IAddr=0x40, MemRdata=0x8C010004 → MemReq high in cycle 2, IValid in cycle 3, IRdata=0x8C010004, StallF=1 for cycles 1–3.
- Store then load, MemReady after 2 wait cycles:
  - Store DAddr=0x100, DWdata=0xDEADBEEF → MemWe=1, DValid pulse, DRdata stays 0.
  - Load DAddr=0x100 with memory returning 0xDEADBEEF → DRdata=0xDEADBEEF.
- Simultaneous IReq and DReq in IDLE → BUSY_D granted first; fetch is granted on the next IDLE cycle; StallF stays 1 throughout.
- IFlush=1 during BUSY_I with MemRdata=0x12345678 → MemReq completes, IValid never pulses, IRdata keeps its old value.
- RST_N pulled low in BUSY_D with MemReq=1 → same cycle MemReq=0 and Busy=0, with no DValid after release.
- MEM_ARB_FAIR_EN, STARVE_MAX=4, DReq and IReq held constantly → grant order is D,D,D,D,I,D,D,D,D,I.
